// File: rtl/fp8_pkg.sv
// Shared FP8 definitions for the multiply path.
//   FP8 format is 1-4-3 (sign, exponent, mantissa) with exponent bias 7.
//   req_state_t is the state encoding of the multiplier requester FSM.
package fp8_pkg;

  localparam int FP8_W    = 8;
  localparam int EXP_W    = 4;
  localparam int MAN_W    = 3;
  localparam int EXP_BIAS = 7;

  typedef logic [FP8_W-1:0] fp8_t;

  localparam fp8_t FP8_ZERO = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } req_state_t;

endpackage

// File: rtl/fp8_mul_requester.sv
// Initiator side of the FP8 multiplier start/done handshake.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operand stream (in_a, in_b)
//   start_mul, mul_a, mul_b  one-cycle request and operands to the multiplier
//   done_mul, product        multiplier completion and result
//   out_valid/out_ready      result stream (out_product, out_timeout)
//   busy                     FSM is not in IDLE
//   op_count                 completed result handshakes (wraps)
//   timeout_count            aborted operations (saturates)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE. Once out_valid rises, it and
// out_product/out_timeout stay fixed until the edge where out_ready is seen.
//
// Operation flow: IDLE accepts operands, ISSUE pulses start_mul, WAIT runs
// the timer until done_mul or timeout, HOLD presents the result. A done_mul
// outside WAIT is a leftover from a dropped transaction and is ignored.
module fp8_mul_requester
  import fp8_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             start_mul,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic             done_mul,
  input  logic [7:0]       product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_product,
  output logic             out_timeout,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] timeout_count
);

  // Timer only needs to reach TIMEOUT_CYCLES-1; WAIT is left on that cycle.
  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  req_state_t       state, state_next;
  logic [TMR_W-1:0] timer;

  logic accept;      // operand pair transferred this cycle
  logic take_done;   // multiplier finished while waiting
  logic take_to;     // waited the full budget without done_mul
  logic release_out; // result transferred downstream this cycle

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    take_done   = 1'b0;
    take_to     = 1'b0;
    release_out = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        // done_mul takes priority over a coinciding timeout.
        if (done_mul) begin
          take_done  = 1'b1;
          state_next = HOLD;
        end else if (timer == TMR_LAST) begin
          take_to    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          release_out = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign start_mul = (state == ISSUE);

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a         <= FP8_ZERO;
      mul_b         <= FP8_ZERO;
      out_valid     <= 1'b0;
      out_product   <= FP8_ZERO;
      out_timeout   <= 1'b0;
      op_count      <= '0;
      timeout_count <= '0;
      timer         <= '0;
    end else begin
      if (accept) begin
        mul_a <= in_a;
        mul_b <= in_b;
      end

      if (state == ISSUE)     timer <= '0;
      else if (state == WAIT) timer <= timer + 1'b1;

      if (take_done) begin
        out_product <= product;
        out_timeout <= 1'b0;
        out_valid   <= 1'b1;
      end else if (take_to) begin
        out_product <= FP8_ZERO;
        out_timeout <= 1'b1;
        out_valid   <= 1'b1;
        if (timeout_count != {CNT_W{1'b1}})
          timeout_count <= timeout_count + 1'b1;
      end

      if (release_out) begin
        out_valid <= 1'b0;
        op_count  <= op_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp8_mul_requester.sv
// Directed bench for fp8_mul_requester. The bench itself plays the part of
// the multiplier (done_mul/product) with hand-computed FP8 products.
module tb_fp8_mul_requester;

  localparam int TO    = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             start_mul;
  logic [7:0]       mul_a;
  logic [7:0]       mul_b;
  logic             done_mul;
  logic [7:0]       product;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_product;
  logic             out_timeout;
  logic             busy;
  logic [CNT_W-1:0] op_count;
  logic [CNT_W-1:0] timeout_count;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int start_cnt  = 0;
  int last_start = 0;
  int first_start;
  int start_base;

  fp8_mul_requester #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .start_mul(start_mul), .mul_a(mul_a), .mul_b(mul_b),
    .done_mul(done_mul), .product(product),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_timeout(out_timeout),
    .busy(busy), .op_count(op_count), .timeout_count(timeout_count)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // start_mul pulse monitor
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (start_mul) begin
      start_cnt  <= start_cnt + 1;
      last_start <= cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Present an operand pair for one edge; leaves the DUT in its first WAIT cycle.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0;
    chk("issue_start", 16'(start_mul), 16'd1);
    chk("issue_mul_a", 16'(mul_a), 16'(a));
    chk("issue_mul_b", 16'(mul_b), 16'(b));
    chk("issue_in_ready", 16'(in_ready), 16'd0);
    tick();
    chk("wait_start_low", 16'(start_mul), 16'd0);
    chk("wait_busy", 16'(busy), 16'd1);
  endtask

  // One-cycle done_mul pulse carrying a product.
  task automatic done_pulse(input logic [7:0] p);
    done_mul = 1'b1; product = p;
    tick();
    done_mul = 1'b0; product = 8'h00;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("rel_out_valid", 16'(out_valid), 16'd0);
    chk("rel_in_ready", 16'(in_ready), 16'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00;
    done_mul = 1'b0; product = 8'h00; out_ready = 1'b0;
    tick(); tick();

    // reset state
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_start", 16'(start_mul), 16'd0);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_out_product", 16'(out_product), 16'h00);
    chk("rst_out_timeout", 16'(out_timeout), 16'd0);
    chk("rst_mul_a", 16'(mul_a), 16'h00);
    chk("rst_op_count", op_count, 16'd0);
    chk("rst_to_count", timeout_count, 16'd0);
    rst = 1'b0;
    tick();

    // -2.0 x 3.5 = -7.0 : 0xC0 x 0x46 -> 0xCE
    start_base = start_cnt;
    issue(8'hC0, 8'h46);
    tick();
    done_pulse(8'hCE);
    chk("t1_out_valid", 16'(out_valid), 16'd1);
    chk("t1_product", 16'(out_product), 16'hCE);
    chk("t1_timeout", 16'(out_timeout), 16'd0);
    release_result();
    chk("t1_op_count", op_count, 16'd1);
    chk("t1_one_start", 16'(start_cnt - start_base), 16'd1);

    // back-pressure: -2.0 x -3.5 = 7.0 : 0xC0 x 0xC6 -> 0x4E
    start_base = start_cnt;
    issue(8'hC0, 8'hC6);
    done_pulse(8'h4E);
    in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34;
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", 16'(out_valid), 16'd1);
      chk("bp_product", 16'(out_product), 16'h4E);
      chk("bp_in_ready", 16'(in_ready), 16'd0);
      chk("bp_start", 16'(start_mul), 16'd0);
      tick();
    end
    in_valid = 1'b0;
    release_result();
    chk("bp_busy", 16'(busy), 16'd0);
    chk("bp_op_count", op_count, 16'd2);
    chk("bp_one_start", 16'(start_cnt - start_base), 16'd1);

    // zero operands back-to-back with in_valid held
    in_valid = 1'b1; in_a = 8'h00; in_b = 8'h46;
    tick();
    in_a = 8'h46; in_b = 8'h00;
    chk("z1_start", 16'(start_mul), 16'd1);
    tick();
    first_start = last_start;
    done_pulse(8'h00);
    chk("z1_product", 16'(out_product), 16'h00);
    chk("z1_out_valid", 16'(out_valid), 16'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();              // second pair accepted on this edge
    in_valid = 1'b0;
    chk("z2_start", 16'(start_mul), 16'd1);
    chk("z2_mul_a", 16'(mul_a), 16'h46);
    tick();
    chk("z_gap", 16'(last_start - first_start), 16'd4);
    done_pulse(8'h00);
    chk("z2_product", 16'(out_product), 16'h00);
    release_result();
    chk("z_op_count", op_count, 16'd4);

    // timeout: no done_mul for TO WAIT cycles
    issue(8'h11, 8'h22);
    for (int k = 0; k < TO; k++) begin
      chk("to_pending", 16'(out_valid), 16'd0);
      chk("to_mul_a", 16'(mul_a), 16'h11);
      tick();
    end
    chk("to_out_valid", 16'(out_valid), 16'd1);
    chk("to_flag", 16'(out_timeout), 16'd1);
    chk("to_product", 16'(out_product), 16'h00);
    chk("to_count", timeout_count, 16'd1);
    done_pulse(8'h77);   // stale in HOLD
    chk("to_stale_product", 16'(out_product), 16'h00);
    chk("to_stale_flag", 16'(out_timeout), 16'd1);
    chk("to_stale_valid", 16'(out_valid), 16'd1);
    chk("to_stale_count", timeout_count, 16'd1);
    release_result();
    chk("to_op_count", op_count, 16'd5);

    // race: done_mul on the final timeout cycle wins
    issue(8'h33, 8'h44);
    for (int k = 0; k < TO - 1; k++) tick();
    chk("race_pending", 16'(out_valid), 16'd0);
    done_pulse(8'h5A);
    chk("race_valid", 16'(out_valid), 16'd1);
    chk("race_flag", 16'(out_timeout), 16'd0);
    chk("race_product", 16'(out_product), 16'h5A);
    chk("race_to_count", timeout_count, 16'd1);
    release_result();

    // reset mid-WAIT, then a stale done_mul
    issue(8'h55, 8'h66);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_in_ready", 16'(in_ready), 16'd1);
    chk("mr_busy", 16'(busy), 16'd0);
    chk("mr_mul_a", 16'(mul_a), 16'h00);
    chk("mr_op_count", op_count, 16'd0);
    chk("mr_to_count", timeout_count, 16'd0);
    done_pulse(8'h99);
    chk("mr_out_valid", 16'(out_valid), 16'd0);
    chk("mr_product", 16'(out_product), 16'h00);
    chk("mr_in_ready2", 16'(in_ready), 16'd1);
    tick();
    chk("mr_out_valid2", 16'(out_valid), 16'd0);
    chk("mr_start", 16'(start_mul), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
